// File: rtl/wb_tlc_req_sched.sv
// Read-side scheduler for the PCIe request FIFO: pops whole TLPs and steers them to the
// write or read engine, rations outstanding reads with credits, and drains non-BAR TLPs.
module wb_tlc_req_sched #(
   parameter int c_DATA_WIDTH = 64,
   parameter int c_MAX_RD     = 4,
   parameter int c_CNT_WIDTH  = 16
) (
   input  logic                    wb_clk,
   input  logic                    rstn,
   input  logic                    tlp_avail,
   output logic                    fifo_ren,
   input  logic [c_DATA_WIDTH-1:0] fifo_dout,
   input  logic                    fifo_sop,
   input  logic                    fifo_eop,
   input  logic                    fifo_wrn,
   input  logic                    fifo_dwen,
   input  logic [6:0]              fifo_bar,
   output logic [c_DATA_WIDTH-1:0] out_data,
   output logic                    out_sop,
   output logic                    out_eop,
   output logic                    out_dwen,
   output logic [6:0]              out_bar,
   output logic                    wr_valid,
   input  logic                    wr_ready,
   output logic                    rd_valid,
   input  logic                    rd_ready,
   input  logic                    rd_cpl_done,
   output logic [3:0]              rd_credits_used,
   output logic [c_CNT_WIDTH-1:0]  drop_cnt,
   output logic                    busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WR,
      S_RD,
      S_RDHOLD,
      S_DROP
   } state_t;

   localparam logic [3:0]             MAX_RD   = 4'(c_MAX_RD);
   localparam logic [c_CNT_WIDTH-1:0] CNT_ONE  = {{(c_CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [c_CNT_WIDTH-1:0] CNT_FULL = {c_CNT_WIDTH{1'b1}};

   state_t                   state_q, state_d;
   logic                     q_vld_q, q_vld_d;
   logic [3:0]               cred_q, cred_d;
   logic [c_CNT_WIDTH-1:0]   drop_q, drop_d;

   logic                     wr_vld, rd_vld, ren, dropping, consume;
   logic                     credit_ok, cred_inc, cred_dec;

   always_comb begin
      state_d   = state_q;
      wr_vld    = 1'b0;
      rd_vld    = 1'b0;
      ren       = 1'b0;
      dropping  = 1'b0;
      credit_ok = (cred_q < MAX_RD);

      case (state_q)
         S_IDLE: begin
            if (tlp_avail) begin
               ren     = 1'b1;
               state_d = S_FETCH;
            end
         end
         // Route is decided on the SOP word itself so the first word can go out this cycle.
         S_FETCH: begin
            if (!fifo_sop || fifo_bar == 7'd0) begin
               state_d = S_DROP;
            end else if (fifo_wrn) begin
               wr_vld  = q_vld_q;
               state_d = S_WR;
            end else if (credit_ok) begin
               rd_vld  = q_vld_q;
               state_d = S_RD;
            end else begin
               state_d = S_RDHOLD;
            end
         end
         S_RDHOLD: begin
            if (credit_ok) state_d = S_RD;
         end
         S_WR:   wr_vld   = q_vld_q;
         S_RD:   rd_vld   = q_vld_q;
         S_DROP: dropping = q_vld_q;
         default: state_d = S_IDLE;
      endcase

      consume = (wr_vld & wr_ready) | (rd_vld & rd_ready) | dropping;
      if (consume) begin
         if (fifo_eop) state_d = S_IDLE;
         else          ren     = 1'b1;
      end

      if (ren)          q_vld_d = 1'b1;
      else if (consume) q_vld_d = 1'b0;
      else              q_vld_d = q_vld_q;

      drop_d = drop_q;
      if (dropping && fifo_eop && drop_q != CNT_FULL) drop_d = drop_q + CNT_ONE;

      // A completion arriving with nothing outstanding is ignored.
      cred_inc = rd_vld & rd_ready & fifo_sop & credit_ok;
      cred_dec = rd_cpl_done & (cred_q != 4'd0);
      cred_d   = cred_q;
      if (cred_inc && !cred_dec)      cred_d = cred_q + 4'd1;
      else if (cred_dec && !cred_inc) cred_d = cred_q - 4'd1;
   end

   always_ff @(posedge wb_clk) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         q_vld_q <= 1'b0;
         cred_q  <= 4'd0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         q_vld_q <= q_vld_d;
         cred_q  <= cred_d;
         drop_q  <= drop_d;
      end
   end

   assign fifo_ren        = ren;
   assign wr_valid        = wr_vld;
   assign rd_valid        = rd_vld;
   assign out_data        = fifo_dout;
   assign out_sop         = fifo_sop;
   assign out_eop         = fifo_eop;
   assign out_dwen        = fifo_dwen;
   assign out_bar         = fifo_bar;
   assign rd_credits_used = cred_q;
   assign drop_cnt        = drop_q;
   assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_wb_tlc_req_sched.sv
// Bench for wb_tlc_req_sched: a FIFO model feeds TLPs from a vector table, plus
// hand sequences for read credits, completion collisions, mid-TLP reset and counter saturation.
module tb_wb_tlc_req_sched;

   typedef struct {
      logic [63:0] data;
      logic        sop;
      logic        eop;
      logic        wrn;
      logic        dwen;
      logic [6:0]  bar;
   } fw_t;

   typedef struct {
      logic       wrn;
      logic [6:0] bar;
      logic       sop;
      int         nw;
      logic [7:0] pat;
      int         route;     // 0 write engine, 1 read engine, 2 dropped
      int         exp_drop;
   } vec_t;

   logic        wb_clk = 1'b0;
   logic        rstn;
   logic        tlp_avail;
   logic        fifo_ren;
   logic [63:0] fifo_dout;
   logic        fifo_sop, fifo_eop, fifo_wrn, fifo_dwen;
   logic [6:0]  fifo_bar;
   logic [63:0] out_data;
   logic        out_sop, out_eop, out_dwen;
   logic [6:0]  out_bar;
   logic        wr_valid, wr_ready, rd_valid, rd_ready, rd_cpl_done;
   logic [3:0]  rd_credits_used;
   logic [15:0] drop_cnt;
   logic        busy;

   logic        s_ren, s_sop, s_eop, s_dwen, s_wv, s_rv, s_busy;
   logic [63:0] s_data;
   logic [6:0]  s_bar;
   logic [3:0]  s_cred;
   logic [1:0]  s_drop;

   int total = 0;
   int bad   = 0;
   int underflow = 0;

   fw_t         fq[$];
   fw_t         q_r;
   logic [64:0] wr_log[$];
   logic [64:0] rd_log[$];
   vec_t        vecs[8];
   vec_t        post_vec;

   always #5 wb_clk = ~wb_clk;

   wb_tlc_req_sched #(.c_DATA_WIDTH(64), .c_MAX_RD(4), .c_CNT_WIDTH(16)) dut (
      .wb_clk(wb_clk), .rstn(rstn), .tlp_avail(tlp_avail), .fifo_ren(fifo_ren),
      .fifo_dout(fifo_dout), .fifo_sop(fifo_sop), .fifo_eop(fifo_eop), .fifo_wrn(fifo_wrn),
      .fifo_dwen(fifo_dwen), .fifo_bar(fifo_bar), .out_data(out_data), .out_sop(out_sop),
      .out_eop(out_eop), .out_dwen(out_dwen), .out_bar(out_bar), .wr_valid(wr_valid),
      .wr_ready(wr_ready), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_cpl_done(rd_cpl_done),
      .rd_credits_used(rd_credits_used), .drop_cnt(drop_cnt), .busy(busy)
   );

   // Narrow-counter instance fed an endless stream of single-word non-BAR TLPs.
   wb_tlc_req_sched #(.c_DATA_WIDTH(64), .c_MAX_RD(4), .c_CNT_WIDTH(2)) dut_sat (
      .wb_clk(wb_clk), .rstn(rstn), .tlp_avail(1'b1), .fifo_ren(s_ren),
      .fifo_dout(64'd0), .fifo_sop(1'b1), .fifo_eop(1'b1), .fifo_wrn(1'b0),
      .fifo_dwen(1'b0), .fifo_bar(7'h00), .out_data(s_data), .out_sop(s_sop),
      .out_eop(s_eop), .out_dwen(s_dwen), .out_bar(s_bar), .wr_valid(s_wv),
      .wr_ready(1'b0), .rd_valid(s_rv), .rd_ready(1'b0), .rd_cpl_done(1'b0),
      .rd_credits_used(s_cred), .drop_cnt(s_drop), .busy(s_busy)
   );

   // FIFO model: Q updates the cycle after ren and holds otherwise; shares rstn.
   always @(posedge wb_clk) begin
      if (!rstn) begin
         fq.delete();
         q_r <= '{default: '0};
      end else if (fifo_ren) begin
         if (fq.size() > 0) q_r <= fq.pop_front();
         else               underflow++;
      end
   end

   assign fifo_dout = q_r.data;
   assign fifo_sop  = q_r.sop;
   assign fifo_eop  = q_r.eop;
   assign fifo_wrn  = q_r.wrn;
   assign fifo_dwen = q_r.dwen;
   assign fifo_bar  = q_r.bar;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge wb_clk);
      #1;
   endtask

   task automatic push_tlp(input int id, input int nw, input logic wrn,
                           input logic [6:0] bar, input logic sop);
      fw_t w;
      for (int k = 0; k < nw; k++) begin
         w.data = 64'(id * 256 + k);
         w.sop  = (k == 0) ? sop : 1'b0;
         w.eop  = (k == nw - 1);
         w.wrn  = wrn;
         w.dwen = k[0];
         w.bar  = bar;
         fq.push_back(w);
      end
   endtask

   task automatic run_vec(input vec_t v, input int id);
      int cyc, nren, vcyc, first;
      logic [64:0] e;
      push_tlp(id, v.nw, v.wrn, v.bar, v.sop);
      wr_log.delete();
      rd_log.delete();
      nren = 0; vcyc = 0; first = -1; cyc = 0;
      tlp_avail = 1'b1;
      while (cyc < 80) begin
         wr_ready = v.pat[cyc % 8];
         rd_ready = v.pat[cyc % 8];
         @(negedge wb_clk);
         if (fifo_ren) nren++;
         if (wr_valid || rd_valid) begin
            vcyc++;
            if (first < 0) first = cyc;
         end
         if (wr_valid && wr_ready) wr_log.push_back({out_eop, out_data});
         if (rd_valid && rd_ready) rd_log.push_back({out_eop, out_data});
         if (wr_valid && rd_valid) chk($sformatf("v%0d_both_valid", id), 1, 0);
         if ((wr_valid && !wr_ready) || (rd_valid && !rd_ready))
            chk($sformatf("v%0d_ren_while_stalled", id), 64'(fifo_ren), 0);
         if (cyc > 0 && !busy) break;
         step();
         tlp_avail = 1'b0;
         cyc++;
      end
      step();
      chk($sformatf("v%0d_finished", id), 64'(cyc < 80), 1);
      chk($sformatf("v%0d_wr_words", id), wr_log.size(), (v.route == 0) ? v.nw : 0);
      chk($sformatf("v%0d_rd_words", id), rd_log.size(), (v.route == 1) ? v.nw : 0);
      for (int k = 0; k < v.nw; k++) begin
         e = {(k == v.nw - 1) ? 1'b1 : 1'b0, 64'(id * 256 + k)};
         if (v.route == 0 && k < wr_log.size()) chk($sformatf("v%0d_wr_w%0d", id, k), wr_log[k], e);
         if (v.route == 1 && k < rd_log.size()) chk($sformatf("v%0d_rd_w%0d", id, k), rd_log[k], e);
      end
      chk($sformatf("v%0d_ren_count", id), nren, v.nw);
      chk($sformatf("v%0d_drop_cnt", id), drop_cnt, v.exp_drop);
      chk($sformatf("v%0d_fifo_empty", id), fq.size(), 0);
      if (v.route == 2) chk($sformatf("v%0d_no_valid", id), vcyc, 0);
      if (v.route != 2 && v.pat == 8'hFF) begin
         chk($sformatf("v%0d_valid_cycles", id), vcyc, v.nw);
         chk($sformatf("v%0d_first_latency", id), first + 1, 2);
      end
      if (v.route == 1) begin
         chk($sformatf("v%0d_credit_taken", id), rd_credits_used, 1);
         rd_cpl_done = 1'b1;
         step();
         rd_cpl_done = 1'b0;
         chk($sformatf("v%0d_credit_returned", id), rd_credits_used, 0);
      end
   endtask

   task automatic rd_run(input int ncyc, input bit cpl_on_sop, inout int nsop, output bit fired);
      fired = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
         tlp_avail = (fq.size() != 0);
         rd_cpl_done = cpl_on_sop && !fired && rd_valid && rd_ready && out_sop;
         if (rd_cpl_done) fired = 1'b1;
         @(negedge wb_clk);
         if (rd_valid && rd_ready) begin
            rd_log.push_back({out_eop, out_data});
            if (out_sop) nsop++;
         end
         step();
      end
      rd_cpl_done = 1'b0;
      tlp_avail   = 1'b0;
   endtask

   initial begin
      int  nsop;
      bit  fired;
      logic [1:0] prev;

      vecs[0] = '{1'b1, 7'h01, 1'b1, 4, 8'hFF, 0, 0};
      vecs[1] = '{1'b1, 7'h01, 1'b1, 4, 8'hD9, 0, 0};
      vecs[2] = '{1'b0, 7'h02, 1'b1, 2, 8'hFF, 1, 0};
      vecs[3] = '{1'b0, 7'h04, 1'b1, 3, 8'h55, 1, 0};
      vecs[4] = '{1'b1, 7'h00, 1'b1, 3, 8'hFF, 2, 1};
      vecs[5] = '{1'b0, 7'h01, 1'b0, 2, 8'hFF, 2, 2};
      vecs[6] = '{1'b1, 7'h01, 1'b1, 1, 8'hFF, 0, 2};
      vecs[7] = '{1'b1, 7'h00, 1'b1, 1, 8'hFF, 2, 3};
      post_vec = '{1'b1, 7'h08, 1'b1, 3, 8'hFF, 0, 0};

      rstn = 1'b0; tlp_avail = 1'b0; wr_ready = 1'b0; rd_ready = 1'b0; rd_cpl_done = 1'b0;
      step(); step();
      chk("rst_fifo_ren", fifo_ren, 0);
      chk("rst_wr_valid", wr_valid, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_credits", rd_credits_used, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
      chk("rst_busy", busy, 0);
      rstn = 1'b1;

      prev = 2'd0;
      for (int c = 0; c < 40; c++) begin
         @(negedge wb_clk);
         chk("sat_monotonic", 64'(s_drop >= prev), 1);
         prev = s_drop;
      end
      chk("sat_drop_cnt", s_drop, 2'd3);
      step();

      foreach (vecs[i]) run_vec(vecs[i], i);

      // Five back-to-back reads against four credits.
      rd_log.delete();
      for (int t = 0; t < 5; t++) push_tlp(20 + t, 2, 1'b0, 7'h01, 1'b1);
      rd_ready = 1'b1; wr_ready = 1'b1; nsop = 0;
      rd_run(40, 1'b0, nsop, fired);
      chk("cred_sops_before", nsop, 4);
      chk("cred_full", rd_credits_used, 4);
      chk("cred_hold_busy", busy, 1);
      chk("cred_hold_no_valid", rd_valid, 0);
      chk("cred_hold_fifo_left", fq.size(), 1);
      rd_cpl_done = 1'b1;
      step();
      rd_cpl_done = 1'b0;
      rd_run(10, 1'b0, nsop, fired);
      chk("cred_sops_after", nsop, 5);
      chk("cred_full_again", rd_credits_used, 4);
      chk("cred_idle", busy, 0);
      chk("cred_words", rd_log.size(), 10);
      for (int k = 0; k < 10 && k < rd_log.size(); k++)
         chk($sformatf("cred_w%0d", k), rd_log[k], {k[0], 64'((20 + k / 2) * 256 + k % 2)});
      for (int k = 0; k < 4; k++) begin
         rd_cpl_done = 1'b1;
         step();
      end
      rd_cpl_done = 1'b0;
      chk("cred_drained", rd_credits_used, 0);
      rd_cpl_done = 1'b1;
      step();
      rd_cpl_done = 1'b0;
      chk("cred_cpl_at_zero", rd_credits_used, 0);

      // Completion coinciding with a read SOP accept at count 2.
      push_tlp(30, 2, 1'b0, 7'h01, 1'b1);
      push_tlp(31, 2, 1'b0, 7'h01, 1'b1);
      nsop = 0;
      rd_run(15, 1'b0, nsop, fired);
      chk("coll_pre_count", rd_credits_used, 2);
      push_tlp(32, 2, 1'b0, 7'h01, 1'b1);
      rd_run(10, 1'b1, nsop, fired);
      chk("coll_cpl_fired", fired, 1);
      chk("coll_sops", nsop, 3);
      chk("coll_count", rd_credits_used, 2);
      rd_cpl_done = 1'b1;
      step();
      rd_cpl_done = 1'b0;
      chk("coll_count_after_one", rd_credits_used, 1);

      // Reset during word 2 of a 6-word write, one credit still outstanding.
      push_tlp(40, 6, 1'b1, 7'h01, 1'b1);
      wr_ready = 1'b1;
      tlp_avail = 1'b1;
      step();
      tlp_avail = 1'b0;
      step();
      chk("mid_rst_word2_valid", wr_valid, 1);
      chk("mid_rst_word2_data", out_data, 64'(40 * 256 + 1));
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      chk("mid_rst_fifo_ren", fifo_ren, 0);
      chk("mid_rst_wr_valid", wr_valid, 0);
      chk("mid_rst_rd_valid", rd_valid, 0);
      chk("mid_rst_credits", rd_credits_used, 0);
      chk("mid_rst_drop_cnt", drop_cnt, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_fifo_flushed", fq.size(), 0);
      run_vec(post_vec, 9);

      chk("fifo_underflow", underflow, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wb_tlc_req_sched.md
Name: wb_tlc_req_sched

Overview:
Read-side scheduler for the PCIe request FIFO in the wb_clk domain. It pops whole TLPs from the FIFO and steers each one, word by word, to either the Wishbone write engine or the read engine, based on the wrn flag in the SOP word. It limits outstanding non-posted reads with a credit counter. It drains and discards TLPs that did not hit a BAR.

Parameters:
c_DATA_WIDTH, 64, TLP data word width; must match the request FIFO.
c_MAX_RD, 4, maximum outstanding read TLPs (1..15).
c_CNT_WIDTH, 16, width of the saturating drop counter.

Ports:
wb_clk  in  1  block clock; the FIFO read clock.
rstn  in  1  synchronous active-low reset.
tlp_avail  in  1  FIFO holds at least one complete TLP.
fifo_ren  out  1  FIFO read enable. Q is valid on the cycle after ren and holds while ren is low.
fifo_dout  in  c_DATA_WIDTH  FIFO data word.
fifo_sop, fifo_eop, fifo_wrn, fifo_dwen  in  1 each  FIFO sideband flags; wrn=1 write, 0 read.
fifo_bar  in  7  BAR-hit vector from the FIFO.
out_data  out  c_DATA_WIDTH  word to the engines; combinational copy of fifo_dout.
out_sop, out_eop, out_dwen  out  1 each  copies of the FIFO flags.
out_bar  out  7  copy of fifo_bar.
wr_valid / wr_ready  out/in  1  handshake with the write engine.
rd_valid / rd_ready  out/in  1  handshake with the read engine.
rd_cpl_done  in  1  single-cycle pulse: one read's completion has finished.
rd_credits_used  out  4  current count of outstanding reads.
drop_cnt  out  c_CNT_WIDTH  number of discarded TLPs; saturates at all-ones.
busy  out  1  state is not IDLE.

Behaviour:
- Reset values: state=IDLE, q_vld=0, fifo_ren=0, wr_valid=0, rd_valid=0, rd_credits_used=0, drop_cnt=0, busy=0. Every flop resets synchronously on rstn=0.
- q_vld is a registered flag meaning fifo_dout holds an unconsumed word. It is set the cycle after any fifo_ren. It clears the cycle after an EOP word is consumed without a new ren.
- A word is "consumed" when it is accepted by the selected engine (valid & ready), or when it is discarded while in DROP.
- States: IDLE, FETCH, WR, RD, RDHOLD, DROP.
- IDLE: if tlp_avail=1, assert fifo_ren for one cycle, then go to FETCH.
- FETCH (SOP word now in Q), decide the route:
  - sop=0 or bar=0: go to DROP.
  - wrn=1: go to WR.
  - wrn=0 and rd_credits_used<c_MAX_RD: go to RD.
  - wrn=0 and credits exhausted: go to RDHOLD.
  - This decision is combinational on the FETCH cycle. The valid output is raised in the same cycle, so first-word latency is 2 clocks from the tlp_avail sample.
- RDHOLD: rd_valid stays low and the word is held in Q. Move to RD on the cycle rd_credits_used<c_MAX_RD.
- WR / RD:
  - valid = q_vld. fifo_ren = valid & ready & ~fifo_eop, which gives 1 word per clock under continuous ready.
  - Consuming the EOP word returns the machine to IDLE. IDLE may issue the next ren on the following cycle.
- DROP: fifo_ren = ~fifo_eop every cycle with q_vld=1. On the EOP word, increment drop_cnt (saturating) and go to IDLE. A single-word TLP (sop & eop) drops in 1 cycle.
- wr_valid and rd_valid are never high together. Neither is high in IDLE, FETCH-to-DROP, DROP or RDHOLD.
- Credits:
  - +1 on rd_valid & rd_ready & out_sop.
  - -1 on rd_cpl_done.
  - Both events in the same cycle leave the count unchanged.
  - rd_cpl_done at 0 is ignored.
  - The count never exceeds c_MAX_RD.
- Data, sop/eop, dwen and bar pass through unregistered and are meaningful only while a valid is high.
- Ready may drop mid-TLP. The word then holds in Q and fifo_ren stays low.
- tlp_avail is sampled only in IDLE. A TLP in progress is never interrupted by tlp_avail changes.
- Reset mid-TLP: the block returns to IDLE with credits 0. The FIFO is reset by the same rstn, so a partial TLP is never resumed.

Test Plan:
- 4-word write TLP (bar=7'h01, wrn=1), wr_ready=1 → wr_valid for exactly 4 consecutive clocks starting 2 clocks after tlp_avail; 4 fifo_ren pulses total; out_eop on the 4th word; back in IDLE after.
- Same TLP with wr_ready toggling 1,0,0,1,1,0,1 → data order preserved; fifo_ren low during every ready=0 cycle; no word duplicated or lost.
- c_MAX_RD=4, five 2-word read TLPs, rd_ready=1, no cpl_done → 4 reads issued, rd_credits_used=4; 5th SOP held in RDHOLD; one rd_cpl_done pulse → 5th read issued, count=4.
- rd_cpl_done in the same cycle as a read SOP accept at count 2 → count stays 2. rd_cpl_done at count 0 → count stays 0.
- TLP with bar=0, then a TLP with sop=0 → both drained with no valid asserted; drop_cnt=2. drop_cnt preloaded to 16'hFFFF plus one more drop → stays 16'hFFFF.
- rstn=0 for 1 clock during word 2 of a 6-word write → next cycle all outputs at reset values and state=IDLE; after FIFO refill, the next TLP is routed normally.
